// File: rtl/npu_input_ctrl_if.sv
// npu_input_ctrl_if: command, CPU beat, PE demand and FIFO/format-register signals of the NPU input sequencer
// slave modport = sequencer side, master modport = CPU/PE/FIFO environment side
interface npu_input_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int LVL_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_format;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_abort;
  logic             in_valid;
  logic             in_ready;
  logic [32:0]      in_data;
  logic             pe_req;
  logic             pe_data_valid;
  logic             npu_input_rst;
  logic             npu_input_interface_conf_data_en;
  logic [15:0]      npu_input_interface_conf_data;
  logic             npu_input_fifo_write_en;
  logic [32:0]      npu_input_data;
  logic             npu_input_fifo_read_en;
  logic             npu_input_fifo_full;
  logic             npu_input_fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             busy;
  logic             batch_done;
  logic             stall_err;
  modport slave (
    input  cmd_valid, cmd_format, cmd_count, cmd_abort, in_valid, in_data, pe_req,
           npu_input_fifo_full, npu_input_fifo_empty,
    output cmd_ready, in_ready, pe_data_valid, npu_input_rst, npu_input_interface_conf_data_en,
           npu_input_interface_conf_data, npu_input_fifo_write_en, npu_input_data,
           npu_input_fifo_read_en, fifo_level, busy, batch_done, stall_err
  );
  modport master (
    output cmd_valid, cmd_format, cmd_count, cmd_abort, in_valid, in_data, pe_req,
           npu_input_fifo_full, npu_input_fifo_empty,
    input  cmd_ready, in_ready, pe_data_valid, npu_input_rst, npu_input_interface_conf_data_en,
           npu_input_interface_conf_data, npu_input_fifo_write_en, npu_input_data,
           npu_input_fifo_read_en, fifo_level, busy, batch_done, stall_err
  );
endinterface

// File: rtl/npu_input_ctrl.sv
// npu_input_ctrl: batch sequencer for the NPU input interface (format register, input FIFO, flush)
// Ports: CLK, npu_rst_n (async active-low), io (npu_input_ctrl_if.slave: command, CPU beats, PE demand, FIFO control, status)
module npu_input_ctrl #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1023
) (
  input logic              CLK,
  input logic              npu_rst_n,
  npu_input_ctrl_if.slave  io
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, CONFIG = 2'd1, RUN = 2'd2, FLUSH = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wr_q, wr_d, rd_q, rd_d;
  logic [15:0]      fmt_q, fmt_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             err_q, err_d, zdone_q, zdone_d, pdv_q, rst_q;
  logic             run, abort, accept, wr_en, rd_en, last, idle_cyc;
  assign run      = state_q == RUN;
  assign abort    = io.cmd_abort & (state_q != IDLE);
  assign accept   = io.cmd_valid & (state_q == IDLE);
  // abort wins over traffic: neither handshake completes in the abort cycle
  assign io.in_ready = run & !abort & !io.npu_input_fifo_full & (lvl_q < LW'(FIFO_DEPTH)) & (wr_q < cnt_q);
  assign wr_en    = io.in_valid & io.in_ready;
  assign rd_en    = run & !abort & io.pe_req & !io.npu_input_fifo_empty & (lvl_q != '0) & (rd_q < cnt_q);
  // the final read's data is presented while rd_q already equals the count
  assign last     = run & pdv_q & (rd_q == cnt_q);
  assign idle_cyc = run & !wr_en & !rd_en;
  assign io.cmd_ready                        = state_q == IDLE;
  assign io.pe_data_valid                    = pdv_q;
  assign io.npu_input_rst                    = rst_q;
  assign io.npu_input_interface_conf_data_en = state_q == CONFIG;
  assign io.npu_input_interface_conf_data    = fmt_q;
  assign io.npu_input_fifo_write_en          = wr_en;
  assign io.npu_input_data                   = io.in_data;
  assign io.npu_input_fifo_read_en           = rd_en;
  assign io.fifo_level                       = lvl_q;
  assign io.busy                             = state_q != IDLE;
  assign io.batch_done                       = zdone_q | (last & !abort);
  assign io.stall_err                        = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fmt_d   = fmt_q;
    wr_d    = wr_q + CNT_W'(wr_en);
    rd_d    = rd_q + CNT_W'(rd_en);
    lvl_d   = lvl_q + LW'(wr_en) - LW'(rd_en);
    tmr_d   = idle_cyc ? ((tmr_q == TW'(TIMEOUT)) ? tmr_q : tmr_q + TW'(1)) : '0;
    err_d   = err_q | (idle_cyc & (tmr_q == TW'(TIMEOUT - 1)));
    zdone_d = accept & (io.cmd_count == '0);
    if (accept) begin
      cnt_d   = io.cmd_count;
      fmt_d   = io.cmd_format;
      wr_d    = '0;
      rd_d    = '0;
      lvl_d   = '0;
      err_d   = 1'b0;
      state_d = (io.cmd_count == '0) ? IDLE : CONFIG;
    end else if (abort) begin
      wr_d    = '0;
      rd_d    = '0;
      lvl_d   = '0;
      state_d = FLUSH;
    end else if (state_q == CONFIG) begin
      state_d = RUN;
    end else if (state_q == FLUSH || last) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fmt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
      pdv_q   <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fmt_q   <= fmt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      zdone_q <= zdone_d;
      pdv_q   <= rd_en;
      rst_q   <= abort;
    end
  end
endmodule

// File: doc/npu_input_ctrl.md
Name: npu_input_ctrl

Overview:
Batch sequencer for the NPU input interface (format register + 16-bit input FIFO + int/float-to-fixed conversion).
- Accepts a per-invocation command (convert format, input count) and programs the interface's format register before any data is written.
- Meters 33-bit CPU input beats into the FIFO.
- Issues FIFO reads on PE demand until the batch is consumed, then reports completion.
- Also owns the interface's synchronous flush/reset.

Parameters:
CNT_W, 8, width of input-count and progress counters (max batch 2^CNT_W-1)
FIFO_DEPTH, 16, input FIFO depth; bounds the occupancy counter
TIMEOUT, 1023, idle cycles in RUN with no write/read before stall error

Ports:
CLK  in  1  system clock
npu_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  batch command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_format  in  16  convert format word ([15]=float, [14:0]=shift/exp bias)
cmd_count  in  CNT_W  number of inputs in batch
cmd_abort  in  1  flush current batch
in_valid  in  1  CPU input beat offered
in_ready  out  1  beat accepted when in_valid&in_ready
in_data  in  33  raw CPU input
pe_req  in  1  PE requests next fixed-point input
pe_data_valid  out  1  FIFO dout valid for PE this cycle
npu_input_rst  out  1  sync reset to interface/FIFO
npu_input_interface_conf_data_en  out  1  format register write strobe
npu_input_interface_conf_data  out  16  format word
npu_input_fifo_write_en  out  1  FIFO write
npu_input_data  out  33  FIFO write data (pass-through of in_data)
npu_input_fifo_read_en  out  1  FIFO read
npu_input_fifo_full  in  1  FIFO full
npu_input_fifo_empty  in  1  FIFO empty
fifo_level  out  log2(FIFO_DEPTH)+1  tracked occupancy
busy  out  1  state != IDLE
batch_done  out  1  one-cycle pulse at batch completion
stall_err  out  1  sticky stall flag; cleared on next accepted command

Behaviour:
- Reset (npu_rst_n=0, async):
  - State=IDLE; all counters and fifo_level=0.
  - batch_done=0, stall_err=0, conf_en=0, pe_data_valid=0.
  - npu_input_rst=1. It is registered and drops on the first CLK edge after npu_rst_n releases.
  - Reset mid-batch discards everything.
- States: IDLE, CONFIG, RUN, FLUSH.
- IDLE:
  - cmd_ready=1.
  - On accept, latch count and format.
  - If count==0: pulse batch_done next cycle, stay IDLE.
  - Otherwise go to CONFIG.
- CONFIG (exactly 1 cycle):
  - conf_en=1 with the latched format; go to RUN.
  - Format lands before the first write, because in_ready=0 outside RUN.
- RUN:
  - in_ready = !full & (fifo_level<FIFO_DEPTH) & (wr_cnt<count).
  - write_en = in_valid & in_ready (combinational); npu_input_data=in_data.
  - read_en = pe_req & !empty & (fifo_level!=0) & (rd_cnt<count).
  - pe_data_valid = read_en delayed 1 cycle (FIFO read latency 1).
  - fifo_level: +1 on write, -1 on read; unchanged on simultaneous write and read.
  - Exit: when rd_cnt reaches count and the final pe_data_valid has been issued, pulse batch_done in that same cycle and go to IDLE.
- Stall timer:
  - Increments in RUN on cycles with no write and no read; clears on any write or read.
  - At TIMEOUT: set stall_err (sticky) and stay in RUN.
- cmd_abort (any non-IDLE state) goes to FLUSH.
- FLUSH:
  - npu_input_rst=1 for exactly 1 cycle, which also clears the interface format register.
  - Counters and fifo_level=0, no batch_done; then IDLE.
  - Abort in IDLE is ignored.
  - Abort has priority over a same-cycle write or read; neither is issued.
- cmd_valid outside IDLE is held off (cmd_ready=0).
- Counters never wrap: wr_cnt and rd_cnt saturate at count by the gating above.

Test Plan:
1. Reset, then cmd format=0x0007, count=3:
   - conf_en pulses once with 0x0007 one cycle after accept.
   - 3 beats written, 3 pe_req reads.
   - pe_data_valid on 3 cycles; batch_done on the cycle of the 3rd pe_data_valid, then IDLE.
2. count=20, FIFO_DEPTH=16, pe_req=0:
   - in_ready drops after 16 writes; fifo_level=16.
   - Raising pe_req drains; remaining 4 writes complete; batch_done after 20 reads.
3. Same-cycle write and read with fifo_level=5 -> fifo_level stays 5; both counters advance by 1.
4. cmd_count=0 -> no conf_en, no FIFO traffic; batch_done one cycle after accept; busy stays 0.
5. Abort after 2 of 4 writes:
   - npu_input_rst high exactly 1 cycle; fifo_level=0; no batch_done; next command accepted normally.
6. RUN with no traffic for TIMEOUT cycles -> stall_err=1 and stays set; next accepted command clears it. Async reset mid-RUN -> all outputs at reset values immediately.
